// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bit positions for the pipelined ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  localparam int FLAGS_W = 4;
  localparam int FLAG_C  = 3;
  localparam int FLAG_Z  = 2;
  localparam int FLAG_N  = 1;
  localparam int FLAG_V  = 0;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand and result handshake bundle between an operand source and the ALU.
interface alu_pipe_if #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic [3:0]       out_flags;
  logic [TAG_W-1:0] out_tag;

  // Environment side: issues operations and consumes results.
  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_flags, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_flags, out_tag
  );
endinterface

// File: rtl/wide_adder.sv
// Combinational WIDTH-bit adder with carry in and carry out.
module wide_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: S1 holds operands, S2 holds result, flags and tag.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input logic      clk,
  input logic      rst_n,
  alu_pipe_if.slave bus
);

  logic             s1_v;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [TAG_W-1:0] s1_tag;

  logic               s2_v;
  logic [WIDTH-1:0]   s2_res;
  logic [FLAGS_W-1:0] s2_flags;
  logic [TAG_W-1:0]   s2_tag;

  logic s2_adv;
  logic in_fire;

  assign s2_adv       = !s2_v || bus.out_ready;
  assign bus.in_ready = !s1_v || s2_adv;
  assign in_fire      = bus.in_valid && bus.in_ready;

  assign bus.out_valid = s2_v;
  assign bus.out_res   = s2_res;
  assign bus.out_flags = s2_flags;
  assign bus.out_tag   = s2_tag;

  // SUB and CMP reuse the adder as a + ~b + 1.
  logic             sub_op;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  assign sub_op = (s1_op == OP_SUB) || (s1_op == OP_CMP);
  assign add_b  = sub_op ? ~s1_b : s1_b;
  assign ovf    = (s1_a[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);

  wide_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (s1_a),
    .b    (add_b),
    .cin  (sub_op),
    .sum  (sum),
    .cout (cout)
  );

  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   flag_src;
  logic [FLAGS_W-1:0] alu_flags;
  logic               c_bit;
  logic               v_bit;

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    alu_res = sum;
    c_bit   = 1'b0;
    v_bit   = 1'b0;
    case (s1_op)
      OP_ADD: begin c_bit = cout;  v_bit = ovf; end
      OP_SUB: begin c_bit = ~cout; v_bit = ovf; end
      OP_AND: alu_res = s1_a & s1_b;
      OP_OR:  alu_res = s1_a | s1_b;
      OP_XOR: alu_res = s1_a ^ s1_b;
      OP_SHL: begin alu_res = {s1_a[WIDTH-2:0], 1'b0}; c_bit = s1_a[WIDTH-1]; end
      OP_SHR: begin alu_res = {1'b0, s1_a[WIDTH-1:1]}; c_bit = s1_a[0]; end
      default: begin alu_res = s1_a; c_bit = ~cout; v_bit = ovf; end
    endcase
    // CMP reports Z/N of the difference while passing A through.
    flag_src          = (s1_op == OP_CMP) ? sum : alu_res;
    alu_flags         = '0;
    alu_flags[FLAG_C] = c_bit;
    alu_flags[FLAG_Z] = (flag_src == '0);
    alu_flags[FLAG_N] = flag_src[WIDTH-1];
    alu_flags[FLAG_V] = v_bit;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v     <= 1'b0;
      s2_v     <= 1'b0;
      s2_res   <= '0;
      s2_flags <= '0;
      s2_tag   <= '0;
    end else begin
      if (in_fire)     s1_v <= 1'b1;
      else if (s2_adv) s1_v <= 1'b0;
      if (s2_adv)      s2_v <= s1_v;
      if (s2_adv && s1_v) begin
        s2_res   <= alu_res;
        s2_flags <= alu_flags;
        s2_tag   <= s1_tag;
      end
    end
  end

  // NOTE: S1 payload needs no reset; it is only consumed while s1_v, which is reset.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_op  <= bus.in_op;
      s1_a   <= bus.in_a;
      s1_b   <= bus.in_b;
      s1_tag <= bus.in_tag;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vectors, backpressure, streaming, reset.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 8;
  localparam int T = 4;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [T-1:0] tag;
  } in_t;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flags;
    logic [T-1:0] tag;
    int           born;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(W), .TAG_W(T)) bus ();

  alu_pipe #(.WIDTH(W), .TAG_W(T)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  exp_t         q[$];
  in_t          pend[$];
  int           drain_log[$];
  logic         accepted;
  logic         drained;
  logic [W-1:0] last_res;
  logic [3:0]   last_flags;
  logic [T-1:0] last_tag;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, result {res, C, Z, N, V}.
  function automatic logic [W+3:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int ua, ub, sa, sb, s;
    logic [W-1:0] res, diff;
    logic c, z, n, v;
    ua = int'(a);  ub = int'(b);
    sa = int'($signed(a));  sb = int'($signed(b));
    diff = W'(ua - ub);
    c = 1'b0;  v = 1'b0;
    case (op)
      OP_ADD: begin res = W'(ua + ub); c = (ua + ub) > 255; s = sa + sb; v = (s > 127) || (s < -128); end
      OP_SUB: begin res = diff; c = ua < ub; s = sa - sb; v = (s > 127) || (s < -128); end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_SHL: begin res = W'(ua * 2); c = ua >= 128; end
      OP_SHR: begin res = W'(ua / 2); c = (ua % 2) == 1; end
      default: begin res = a; c = ua < ub; s = sa - sb; v = (s > 127) || (s < -128); end
    endcase
    z = (res == 0);
    n = int'(res) >= 128;
    if (op == OP_CMP) begin
      z = (ua == ub);
      n = int'(diff) >= 128;
    end
    return {res, c, z, n, v};
  endfunction

  task automatic drive(input in_t x);
    bus.in_valid = 1'b1;
    bus.in_op    = x.op;
    bus.in_a     = x.a;
    bus.in_b     = x.b;
    bus.in_tag   = x.tag;
  endtask

  // One clock: check the cycle's outputs at negedge, update the model, then step.
  task automatic cycle();
    exp_t e;
    logic [W+3:0] r;
    logic ov_exp;
    @(negedge clk);
    check("in_ready", bus.in_ready, (q.size() < 2) || bus.out_ready);
    ov_exp = 1'b0;
    if (q.size() > 0) ov_exp = (cyc > q[0].born);
    check("out_valid", bus.out_valid, ov_exp);
    if (bus.out_valid && q.size() > 0) begin
      check("out_res", bus.out_res, q[0].res);
      check("out_flags", bus.out_flags, q[0].flags);
      check("out_tag", bus.out_tag, q[0].tag);
    end
    drained  = bus.out_valid && bus.out_ready;
    accepted = bus.in_valid && bus.in_ready;
    if (drained) begin
      last_res   = bus.out_res;
      last_flags = bus.out_flags;
      last_tag   = bus.out_tag;
      drain_log.push_back(cyc);
      if (q.size() > 0) void'(q.pop_front());
    end
    if (accepted) begin
      r       = ref_alu(bus.in_op, bus.in_a, bus.in_b);
      e.res   = r[W+3:4];
      e.flags = r[3:0];
      e.tag   = bus.in_tag;
      e.born  = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
    q.delete();
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_res", bus.out_res, '0);
    check("rst_out_flags", bus.out_flags, '0);
    check("rst_out_tag", bus.out_tag, '0);
    check("rst_in_ready", bus.in_ready, 1'b1);
  endtask

  task automatic send(input string name, input logic [2:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [T-1:0] tag,
                      input logic [W-1:0] exp_res, input logic [3:0] exp_flags);
    in_t x;
    x.op = op;  x.a = a;  x.b = b;  x.tag = tag;
    bus.out_ready = 1'b1;
    drive(x);
    cycle();
    check({name, "_accept"}, accepted, 1'b1);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8 && q.size() > 0; i++) cycle();
    check({name, "_done"}, q.size(), 0);
    check({name, "_res"}, last_res, exp_res);
    check({name, "_flags"}, last_flags, exp_flags);
    check({name, "_tag"}, last_tag, tag);
  endtask

  // Present pend[] in order with the given out_ready policy until all drained.
  task automatic run_pend(input int max_cycles, input bit rand_ready, output int used);
    used = 0;
    while ((pend.size() > 0 || q.size() > 0) && used < max_cycles) begin
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
      if (pend.size() > 0) drive(pend[0]);
      else bus.in_valid = 1'b0;
      cycle();
      if (accepted) void'(pend.pop_front());
      used++;
    end
    bus.in_valid = 1'b0;
    check("run_finished", (pend.size() == 0) && (q.size() == 0), 1'b1);
  endtask

  initial begin
    int used, acc_stall;
    in_t x;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;

    do_reset();

    send("add",  OP_ADD, 8'hF0, 8'h20, 4'd3, 8'h10, 4'b1000);
    send("sub1", OP_SUB, 8'h03, 8'h05, 4'd1, 8'hFE, 4'b1010);
    send("sub2", OP_SUB, 8'h80, 8'h01, 4'd2, 8'h7F, 4'b0001);
    send("cmp",  OP_CMP, 8'h05, 8'h05, 4'd4, 8'h05, 4'b0100);
    send("shl",  OP_SHL, 8'h81, 8'h00, 4'd5, 8'h02, 4'b1000);
    send("shr",  OP_SHR, 8'h81, 8'h00, 4'd6, 8'h40, 4'b1000);
    send("xor",  OP_XOR, 8'hFF, 8'h0F, 4'd7, 8'hF0, 4'b0010);
    send("and",  OP_AND, 8'h0F, 8'hF0, 4'd8, 8'h00, 4'b0100);
    send("or",   OP_OR,  8'h50, 8'h0A, 4'd9, 8'h5A, 4'b0000);

    // Backpressure: four back-to-back ops against a stalled consumer.
    for (int i = 0; i < 4; i++) begin
      x.op  = 3'($urandom_range(0, 7));
      x.a   = 8'($urandom);
      x.b   = 8'($urandom);
      x.tag = 4'(10 + i);
      pend.push_back(x);
    end
    bus.out_ready = 1'b0;
    acc_stall = 0;
    for (int i = 0; i < 5; i++) begin
      drive(pend[0]);
      cycle();
      if (accepted) begin
        void'(pend.pop_front());
        acc_stall++;
      end
    end
    check("bp_accepts", acc_stall, 2);
    check("bp_ready_low", bus.in_ready, 1'b0);
    drain_log.delete();
    bus.out_ready = 1'b1;
    run_pend(20, 1'b0, used);
    check("bp_drains", drain_log.size(), 4);

    // Streaming: one op per cycle, results must drain on consecutive cycles.
    for (int i = 0; i < 16; i++) begin
      x.op  = 3'($urandom_range(0, 7));
      x.a   = 8'($urandom);
      x.b   = 8'($urandom);
      x.tag = 4'($urandom);
      pend.push_back(x);
    end
    drain_log.delete();
    bus.out_ready = 1'b1;
    run_pend(40, 1'b0, used);
    check("stream_drains", drain_log.size(), 16);
    if (drain_log.size() == 16)
      check("stream_consecutive", drain_log[15] - drain_log[0], 15);
    check("stream_cycles", used, 18);

    // Random consumer stalls with random operands.
    for (int i = 0; i < 32; i++) begin
      x.op  = 3'($urandom_range(0, 7));
      x.a   = 8'($urandom);
      x.b   = 8'($urandom);
      x.tag = 4'($urandom);
      pend.push_back(x);
    end
    run_pend(300, 1'b1, used);

    // Reset with both stages full discards everything.
    bus.out_ready = 1'b0;
    x.op = OP_ADD;  x.a = 8'h11;  x.b = 8'h22;  x.tag = 4'hA;
    for (int i = 0; i < 3; i++) begin
      drive(x);
      cycle();
      x.tag = x.tag + 4'd1;
    end
    check("full_before_reset", q.size(), 2);
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    send("post_rst", OP_SUB, 8'h10, 8'h01, 4'hC, 8'h0F, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
